sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SDRAM row/column address width.
REQ-002 Parameter BA_WIDTH, default 2, SDRAM bank address width.
REQ-003 clk  input  1  single system clock; all logic rises on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 init_end  input  1  init sequence complete; level, stays high after completion.
REQ-006 init_cmd / init_addr  input  4 / ADDR_WIDTH  init sub-block command {cs_n,ras_n,cas_n,we_n} and address.
REQ-007 ref_rq, ref_end  input  1 each  refresh request (level) and refresh done.
REQ-008 ref_cmd / ref_addr  input  4 / ADDR_WIDTH  refresh sub-block command and address.
REQ-009 wr_rq, wr_end  input  1 each  write request (level) and write done.
REQ-010 wr_cmd / wr_addr / wr_ba  input  4 / ADDR_WIDTH / BA_WIDTH  write sub-block command, address, bank.
REQ-011 rd_rq, rd_end  input  1 each  read request (level) and read done.
REQ-012 rd_cmd / rd_addr / rd_ba  input  4 / ADDR_WIDTH / BA_WIDTH  read sub-block command, address, bank.
REQ-013 ref_en, wr_en, rd_en  output  1 each  one-cycle grant pulses to the sub-blocks.
REQ-014 sdram_cke  output  1  SDRAM clock enable.
REQ-015 sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  output  1 each  SDRAM command pins.
REQ-016 sdram_addr / sdram_ba  output  ADDR_WIDTH / BA_WIDTH  SDRAM address and bank pins.

Function
REQ-017 FSM states SHALL be IDLE, INIT, ARBIT, REF, WRITE, READ, held in a registered state variable.
REQ-018 IDLE SHALL go to INIT on the first clock after reset release.
REQ-019 INIT SHALL go to ARBIT on the cycle init_end is sampled high; no grant is issued before this.
REQ-020 In ARBIT, priority SHALL be ref_rq > wr_rq > rd_rq; simultaneous requests go to the highest-priority requester.
REQ-021 Leaving ARBIT for REF/WRITE/READ, the matching *_en SHALL be high for exactly that one cycle, registered on the same edge as the state change.
REQ-022 REF/WRITE/READ SHALL return to ARBIT on the cycle after the matching *_end is sampled high; other requests are ignored meanwhile (no preemption).
REQ-023 At least one ARBIT cycle SHALL separate consecutive grants, even when a request is pending as *_end arrives.
REQ-024 {cs_n,ras_n,cas_n,we_n}, addr and ba SHALL be muxed combinationally from the registered state: INIT->init_*, REF->ref_*, WRITE->wr_*, READ->rd_*; IDLE/ARBIT->NOP (4'b0111), addr 0, ba 0.
REQ-025 ba SHALL be 0 in INIT and REF.
REQ-026 sdram_cke SHALL be 1 in every state except IDLE.
REQ-027 *_end arriving in a state that does not own it SHALL be ignored.

Reset
REQ-028 While rst is high: state=IDLE, all *_en=0, command pins NOP, addr=0, ba=0, cke=0.
REQ-029 rst asserted mid-transaction SHALL abort immediately with no drain; after release, the sequence restarts at IDLE->INIT.

Configuration
REQ-030 With SDRAM_ARB_RR_EN defined, write/read priority SHALL alternate: after a WRITE grant, read wins the next simultaneous wr_rq/rd_rq tie, and vice versa; refresh stays highest. The alternation flag resets to "write first".
REQ-031 Without SDRAM_ARB_RR_EN, fixed priority per REQ-020 applies and no alternation flag exists.

Structure
REQ-032 The command encodings (NOP, PRECHARGE, AUTO_REFRESH, MRS, ACTIVE, READ, WRITE) and the state enumeration SHALL live in the shared SDRAM parameter package used by all SDRAM sub-blocks.
REQ-033 The block is a single module with no sub-modules; the output mux is inline.

Verification
REQ-034 Reset, then init_end=1 at cycle 10 -> state INIT until cycle 10, ARBIT at cycle 11, pins NOP, cke=1 from cycle 1.
REQ-035 ref_rq, wr_rq and rd_rq all raised the same cycle in ARBIT -> ref_en pulses once, pins follow ref_cmd (4'b0001) until ref_end, then one ARBIT cycle, then wr_en.
REQ-036 ref_rq raised during WRITE -> no ref_en until the cycle after wr_end plus one ARBIT cycle; write command stream uninterrupted.
REQ-037 rd_rq held, rd_end pulsed with rd_rq still high -> ARBIT cycle, then second rd_en; sdram_ba tracks rd_ba=2'b10 only in READ.
REQ-038 rst pulsed high for 1 cycle mid-READ -> pins immediately NOP/0, cke=0, rd_en never re-pulses before a new ARBIT.
REQ-039 With SDRAM_ARB_RR_EN, wr_rq and rd_rq held continuously -> grants alternate WRITE, READ, WRITE, READ.

Source files
------------

// File: rtl/sdram_arbit_pkg.sv
// Shared SDRAM parameter package: command encodings, arbiter states and grant codes.
// Used by every SDRAM sub-block (init, refresh, write, read, arbiter).
package sdram_arbit_pkg;

    // Commands are {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_MRS          = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ARBIT = 3'd2,
        ST_REF   = 3'd3,
        ST_WRITE = 3'd4,
        ST_READ  = 3'd5
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REF  = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } arb_gnt_t;

    function automatic logic is_known_cmd(input logic [3:0] cmd);
        return (cmd == CMD_NOP)          || (cmd == CMD_PRECHARGE) ||
               (cmd == CMD_AUTO_REFRESH) || (cmd == CMD_MRS)       ||
               (cmd == CMD_ACTIVE)       || (cmd == CMD_READ)      ||
               (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: sequences init, then grants refresh > write > read.
// Define SDRAM_ARB_RR_EN to alternate write/read priority on simultaneous requests.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BA_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  init_end,
    input  logic [3:0]            init_cmd,
    input  logic [ADDR_WIDTH-1:0] init_addr,

    input  logic                  ref_rq,
    input  logic                  ref_end,
    input  logic [3:0]            ref_cmd,
    input  logic [ADDR_WIDTH-1:0] ref_addr,

    input  logic                  wr_rq,
    input  logic                  wr_end,
    input  logic [3:0]            wr_cmd,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BA_WIDTH-1:0]   wr_ba,

    input  logic                  rd_rq,
    input  logic                  rd_end,
    input  logic [3:0]            rd_cmd,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [BA_WIDTH-1:0]   rd_ba,

    output logic                  ref_en,
    output logic                  wr_en,
    output logic                  rd_en,

    output logic                  sdram_cke,
    output logic                  sdram_cs_n,
    output logic                  sdram_ras_n,
    output logic                  sdram_cas_n,
    output logic                  sdram_we_n,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [BA_WIDTH-1:0]   sdram_ba
);

    arb_state_t state_q;
    logic       ref_en_q;
    logic       wr_en_q;
    logic       rd_en_q;
    arb_gnt_t   gnt_d;
    logic       wr_wins;

`ifdef SDRAM_ARB_RR_EN
    // Set after a write grant so that read wins the next write/read tie
    logic       rd_first_q;

    assign wr_wins = wr_rq && !(rd_rq && rd_first_q);
`else
    assign wr_wins = wr_rq;
`endif

    always_comb begin
        gnt_d = GNT_NONE;
        if (ref_rq) begin
            gnt_d = GNT_REF;
        end else if (wr_wins) begin
            gnt_d = GNT_WR;
        end else if (rd_rq) begin
            gnt_d = GNT_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ref_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            rd_first_q <= 1'b0;
`endif
        end else begin
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_INIT;
                end
                ST_INIT: begin
                    if (init_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    unique case (gnt_d)
                        GNT_REF: begin
                            state_q  <= ST_REF;
                            ref_en_q <= 1'b1;
                        end
                        GNT_WR: begin
                            state_q    <= ST_WRITE;
                            wr_en_q    <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                            rd_first_q <= 1'b1;
`endif
                        end
                        GNT_RD: begin
                            state_q    <= ST_READ;
                            rd_en_q    <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                            rd_first_q <= 1'b0;
`endif
                        end
                        default: begin
                            state_q <= ST_ARBIT;
                        end
                    endcase
                end
                // Owners run to completion; other requests wait in ARBIT
                ST_REF: begin
                    if (ref_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        state_q <= ST_ARBIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ref_en = ref_en_q;
    assign wr_en  = wr_en_q;
    assign rd_en  = rd_en_q;

    logic [3:0]            cmd_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [BA_WIDTH-1:0]   ba_d;

    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        unique case (state_q)
            ST_INIT: begin
                cmd_d  = init_cmd;
                addr_d = init_addr;
            end
            ST_REF: begin
                cmd_d  = ref_cmd;
                addr_d = ref_addr;
            end
            ST_WRITE: begin
                cmd_d  = wr_cmd;
                addr_d = wr_addr;
                ba_d   = wr_ba;
            end
            ST_READ: begin
                cmd_d  = rd_cmd;
                addr_d = rd_addr;
                ba_d   = rd_ba;
            end
            default: begin
                cmd_d  = CMD_NOP;
                addr_d = '0;
                ba_d   = '0;
            end
        endcase
    end

    assign sdram_cke   = (state_q != ST_IDLE);
    assign sdram_cs_n  = cmd_d[3];
    assign sdram_ras_n = cmd_d[2];
    assign sdram_cas_n = cmd_d[1];
    assign sdram_we_n  = cmd_d[0];
    assign sdram_addr  = addr_d;
    assign sdram_ba    = ba_d;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios then random traffic against a cycle model.
// Build with SDRAM_ARB_RR_EN defined to exercise the alternating write/read policy.
module tb_sdram_arbit;
    import sdram_arbit_pkg::*;

    localparam int AW = 12;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_end = 1'b0;
    logic [3:0]    init_cmd = 4'b0111;
    logic [AW-1:0] init_addr = '0;
    logic          ref_rq = 1'b0, ref_end = 1'b0;
    logic [3:0]    ref_cmd = 4'b0001;
    logic [AW-1:0] ref_addr = '0;
    logic          wr_rq = 1'b0, wr_end = 1'b0;
    logic [3:0]    wr_cmd = 4'b0100;
    logic [AW-1:0] wr_addr = '0;
    logic [BW-1:0] wr_ba = '0;
    logic          rd_rq = 1'b0, rd_end = 1'b0;
    logic [3:0]    rd_cmd = 4'b0101;
    logic [AW-1:0] rd_addr = '0;
    logic [BW-1:0] rd_ba = '0;
    logic          ref_en, wr_en, rd_en;
    logic          sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [AW-1:0] sdram_addr;
    logic [BW-1:0] sdram_ba;

    sdram_arbit #(.ADDR_WIDTH(AW), .BA_WIDTH(BW)) dut (
        .clk(clk), .rst(rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_rq(ref_rq), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .wr_rq(wr_rq), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .wr_ba(wr_ba),
        .rd_rq(rd_rq), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .rd_ba(rd_ba),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
        .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
    );

    always #5 clk = ~clk;

    // Reference model: which phase the bus is in, who was just granted,
    // and (alternating build) whether read owns the next tie.
    typedef enum int { P_IDLE, P_INIT, P_ARB, P_REF, P_WR, P_RD } phase_t;
    phase_t m_ph = P_IDLE;
    int     m_gnt = 0;
    bit     m_rd_next = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int choose();
        bit rr;
        rr = 1'b0;
`ifdef SDRAM_ARB_RR_EN
        rr = 1'b1;
`endif
        if (ref_rq) return 1;
        if (wr_rq && rd_rq) return (rr && m_rd_next) ? 3 : 2;
        if (wr_rq) return 2;
        if (rd_rq) return 3;
        return 0;
    endfunction

    task automatic model_edge();
        int g;
        m_gnt = 0;
        if (rst) begin
            m_ph = P_IDLE;
            m_rd_next = 1'b0;
            return;
        end
        case (m_ph)
            P_IDLE: m_ph = P_INIT;
            P_INIT: if (init_end) m_ph = P_ARB;
            P_ARB: begin
                g = choose();
                m_gnt = g;
                if (g != 0) grant_log.push_back(g);
                if (g == 1) m_ph = P_REF;
                if (g == 2) begin m_ph = P_WR; m_rd_next = 1'b1; end
                if (g == 3) begin m_ph = P_RD; m_rd_next = 1'b0; end
            end
            P_REF: if (ref_end) m_ph = P_ARB;
            P_WR:  if (wr_end)  m_ph = P_ARB;
            P_RD:  if (rd_end)  m_ph = P_ARB;
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        logic [3:0] ec;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        ec = 4'b0111; ea = '0; eb = '0;
        if (m_ph == P_INIT) begin ec = init_cmd; ea = init_addr; end
        if (m_ph == P_REF)  begin ec = ref_cmd;  ea = ref_addr;  end
        if (m_ph == P_WR)   begin ec = wr_cmd; ea = wr_addr; eb = wr_ba; end
        if (m_ph == P_RD)   begin ec = rd_cmd; ea = rd_addr; eb = rd_ba; end
        chk("ref_en", ref_en, (m_gnt == 1));
        chk("wr_en",  wr_en,  (m_gnt == 2));
        chk("rd_en",  rd_en,  (m_gnt == 3));
        chk("cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, ec);
        chk("addr", sdram_addr, ea);
        chk("ba", sdram_ba, eb);
        chk("cke", sdram_cke, (m_ph != P_IDLE));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset between edges: outputs must drop immediately
    task automatic async_reset();
        rst = 1'b1;
        #1;
        m_ph = P_IDLE;
        m_gnt = 0;
        m_rd_next = 1'b0;
        check_all();
    endtask

    task automatic rnd_payload();
        init_cmd = 4'($urandom); init_addr = AW'($urandom);
        ref_cmd = 4'($urandom);  ref_addr = AW'($urandom);
        wr_cmd = 4'($urandom);   wr_addr = AW'($urandom); wr_ba = BW'($urandom);
        rd_cmd = 4'($urandom);   rd_addr = AW'($urandom); rd_ba = BW'($urandom);
    endtask

    initial begin
        int n;
        // Reset held: everything idle and quiet
        #1;
        check_all();
        steps(2);
        rst = 1'b0;
        init_addr = 12'h400;
        init_cmd = 4'b0010;
        steps(10);
        init_end = 1'b1;
        steps(3);

        // All three request together: refresh first, then write
        ref_rq = 1'b1; wr_rq = 1'b1; rd_rq = 1'b1;
        ref_addr = 12'h0ab;
        step();
        ref_rq = 1'b0;
        steps(3);
        ref_end = 1'b1; step(); ref_end = 1'b0;
        steps(2);
        wr_rq = 1'b0; rd_rq = 1'b0;

        // Refresh raised during a write waits for the write to finish
        wr_cmd = 4'b0100; wr_addr = 12'h123; wr_ba = 2'b01;
        ref_end = 1'b1;
        steps(2);
        ref_end = 1'b0;
        ref_rq = 1'b1;
        steps(4);
        wr_end = 1'b1; step(); wr_end = 1'b0;
        steps(2);
        ref_rq = 1'b0;
        ref_end = 1'b1; step(); ref_end = 1'b0;
        steps(2);

        // Back-to-back reads separated by an ARBIT cycle
        rd_rq = 1'b1; rd_ba = 2'b10; rd_addr = 12'h055;
        steps(3);
        rd_end = 1'b1; step(); rd_end = 1'b0;
        steps(3);

        // Reset mid-read
        async_reset();
        step();
        rst = 1'b0;
        rd_rq = 1'b1;
        steps(4);
        rd_rq = 1'b0;
        rd_end = 1'b1; step(); rd_end = 1'b0;

        // Write and read held together
        grant_log.delete();
        wr_rq = 1'b1; rd_rq = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            wr_end = 1'b1; rd_end = 1'b1;
            step();
            wr_end = 1'b0; rd_end = 1'b0;
        end
        wr_rq = 1'b0; rd_rq = 1'b0;
        chk("tie_grants", grant_log.size(), 6);
        step();

        // Random traffic with occasional resets and stray end pulses
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            rnd_payload();
            ref_rq = ($urandom_range(0, 5) == 0);
            wr_rq = ($urandom_range(0, 2) == 0);
            rd_rq = ($urandom_range(0, 2) == 0);
            ref_end = ($urandom_range(0, 3) == 0);
            wr_end = ($urandom_range(0, 3) == 0);
            rd_end = ($urandom_range(0, 3) == 0);
            if (n > 0) n--;
            init_end = (n == 0);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                async_reset();
                init_end = 1'b0;
                n = $urandom_range(1, 6);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
